// File: rtl/conv_stream_sequencer.sv
// conv_stream_sequencer: sequences one accelerator pass. It streams `length`
// words out of the input/weight scratchpads, follows every read through the
// scratchpad and accelerator latency, and writes each result back to the
// output scratchpad.
// Optional feature macro: CONV_SEQ_BASE_ADDR_EN adds per-pass base addresses
// for all three scratchpads. Addresses wrap modulo SIZE.
module conv_stream_sequencer #(
  parameter int NUMHELPER      = 4,
  parameter int INPUT_BITWIDTH = 25,
  parameter int SIZE           = 16,
  parameter int ACC_LATENCY    = 2
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic                                start,
  input  logic [$clog2(SIZE):0]               length,
`ifdef CONV_SEQ_BASE_ADDR_EN
  input  logic [$clog2(SIZE)-1:0]             base_input,
  input  logic [$clog2(SIZE)-1:0]             base_weight,
  input  logic [$clog2(SIZE)-1:0]             base_output,
`endif
  output logic                                busy,
  output logic                                done,
  output logic                                acc_reset,
  output logic                                on_input,
  output logic                                on_weight,
  output logic [$clog2(SIZE)-1:0]             address_input,
  output logic [$clog2(SIZE)-1:0]             address_weight,
  input  logic [NUMHELPER*INPUT_BITWIDTH-1:0] out_c,
  output logic                                on_output,
  output logic                                write_enable_output,
  output logic [$clog2(SIZE)-1:0]             address_output,
  output logic [NUMHELPER*INPUT_BITWIDTH-1:0] data_in_output
);

  localparam int W  = NUMHELPER * INPUT_BITWIDTH;
  localparam int AW = $clog2(SIZE);
  localparam logic [AW:0] SizeWide = (AW+1)'(SIZE);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t r_state;
  state_t w_nextState;

  logic          w_capture;
  logic          w_issueRead;
  logic [AW-1:0] w_readIndexNext;
  logic [AW-1:0] w_baseIn;
  logic [AW-1:0] w_baseWeight;
  logic [AW-1:0] w_baseOut;

  logic [AW-1:0] r_lastIndex;
  logic [AW-1:0] r_readIndex;
  logic          r_onRead;
  logic [AW-1:0] r_addrIn;
  logic [AW-1:0] r_addrWeight;
  logic          r_busy;
  logic          r_done;
  logic          r_accReset;

  // The delay line carries a valid bit and the word index of every issued
  // read. It is fed from the registered read strobe, so the tail entry lines
  // up with the edge on which out_c holds that word's result.
  logic [ACC_LATENCY:0] r_dlValid;
  logic [AW-1:0]        r_dlTag [0:ACC_LATENCY];
  logic                 w_tailValid;
  logic [AW-1:0]        w_tailTag;

  logic          r_writeEn;
  logic          r_writeLast;
  logic [AW-1:0] r_addrOut;
  logic [W-1:0]  r_dataOut;

  // Address arithmetic that stays correct for SIZE values that are not a
  // power of two.
  function automatic logic [AW-1:0] wrapAdd(input logic [AW-1:0] a,
                                            input logic [AW-1:0] b);
    logic [AW:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= SizeWide) begin
      sum = sum - SizeWide;
    end
    return sum[AW-1:0];
  endfunction

`ifdef CONV_SEQ_BASE_ADDR_EN
  logic [AW-1:0] r_baseIn;
  logic [AW-1:0] r_baseWeight;
  logic [AW-1:0] r_baseOut;

  // Bases are frozen on the accepted start so they can change freely mid-pass.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_baseIn     <= '0;
      r_baseWeight <= '0;
      r_baseOut    <= '0;
    end else if (w_capture) begin
      r_baseIn     <= base_input;
      r_baseWeight <= base_weight;
      r_baseOut    <= base_output;
    end
  end

  assign w_baseIn     = (r_state == IDLE) ? base_input  : r_baseIn;
  assign w_baseWeight = (r_state == IDLE) ? base_weight : r_baseWeight;
  assign w_baseOut    = r_baseOut;
`else
  assign w_baseIn     = '0;
  assign w_baseWeight = '0;
  assign w_baseOut    = '0;
`endif

  assign w_tailValid = r_dlValid[ACC_LATENCY];
  assign w_tailTag   = r_dlTag[ACC_LATENCY];

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next state and read issue. The read for the first word is issued on the
  // same edge that accepts start, so the read counter always holds the index
  // of the read currently on the scratchpad address bus.
  always_comb begin
    w_nextState     = r_state;
    w_capture       = 1'b0;
    w_issueRead     = 1'b0;
    w_readIndexNext = r_readIndex;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_capture = 1'b1;
          if (length == '0) begin
            w_nextState = DONE;
          end else begin
            w_nextState     = RUN;
            w_issueRead     = 1'b1;
            w_readIndexNext = '0;
          end
        end
      end
      RUN: begin
        if (r_readIndex == r_lastIndex) begin
          w_nextState = DRAIN;
        end else begin
          w_issueRead     = 1'b1;
          w_readIndexNext = r_readIndex + 1'b1;
        end
      end
      DRAIN: begin
        if (r_writeEn && r_writeLast) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Read side and pass status, registered from the next state so every
  // output comes straight from a flop.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lastIndex  <= '0;
      r_readIndex  <= '0;
      r_onRead     <= 1'b0;
      r_addrIn     <= '0;
      r_addrWeight <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_accReset   <= 1'b1;
    end else begin
      if (w_capture) begin
        r_lastIndex <= length[AW-1:0] - {{(AW-1){1'b0}}, 1'b1};
      end
      r_onRead <= w_issueRead;
      if (w_issueRead) begin
        r_readIndex  <= w_readIndexNext;
        r_addrIn     <= wrapAdd(w_baseIn, w_readIndexNext);
        r_addrWeight <= wrapAdd(w_baseWeight, w_readIndexNext);
      end
      r_busy     <= (w_nextState == RUN) || (w_nextState == DRAIN) ||
                    ((w_nextState == DONE) && (r_state == IDLE));
      r_done     <= (w_nextState == DONE);
      r_accReset <= !((w_nextState == RUN) || (w_nextState == DRAIN));
    end
  end

  // Shift every issued read down the delay line toward the write stage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_dlValid <= '0;
      for (int i = 0; i <= ACC_LATENCY; i++) begin
        r_dlTag[i] <= '0;
      end
    end else begin
      r_dlValid[0] <= r_onRead;
      r_dlTag[0]   <= r_readIndex;
      for (int i = 1; i <= ACC_LATENCY; i++) begin
        r_dlValid[i] <= r_dlValid[i-1];
        r_dlTag[i]   <= r_dlTag[i-1];
      end
    end
  end

  // Write stage: when a tag leaves the delay line, latch the accelerator
  // result and pulse the output scratchpad write for one cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_writeEn   <= 1'b0;
      r_writeLast <= 1'b0;
      r_addrOut   <= '0;
      r_dataOut   <= '0;
    end else begin
      r_writeEn <= w_tailValid;
      if (w_tailValid) begin
        r_dataOut   <= out_c;
        r_addrOut   <= wrapAdd(w_baseOut, w_tailTag);
        r_writeLast <= (w_tailTag == r_lastIndex);
      end else begin
        r_writeLast <= 1'b0;
      end
    end
  end

  assign busy                = r_busy;
  assign done                = r_done;
  assign acc_reset           = r_accReset;
  assign on_input            = r_onRead;
  assign on_weight           = r_onRead;
  assign address_input       = r_addrIn;
  assign address_weight      = r_addrWeight;
  assign on_output           = r_writeEn;
  assign write_enable_output = r_writeEn;
  assign address_output      = r_addrOut;
  assign data_in_output      = r_dataOut;

endmodule

// File: tb/tb_conv_stream_sequencer.sv
// tb_conv_stream_sequencer: drives conv_stream_sequencer against behavioural
// scratchpads and an XOR stub accelerator. Expected reads and writes are
// queued when a pass is launched and popped as the DUT produces them.
// Define CONV_SEQ_BASE_ADDR_EN to also exercise the base-address variant.
module tb_conv_stream_sequencer;

  localparam int NH   = 4;
  localparam int IBW  = 25;
  localparam int SIZE = 16;
  localparam int LAT  = 2;
  localparam int W    = NH * IBW;
  localparam int AW   = $clog2(SIZE);

  typedef struct {
    int            cycle;
    logic [AW-1:0] addr;
    logic [AW-1:0] addrW;
    logic [W-1:0]  data;
  } expect_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic [AW:0]   length;
  logic          busy;
  logic          done;
  logic          acc_reset;
  logic          on_input;
  logic          on_weight;
  logic [AW-1:0] address_input;
  logic [AW-1:0] address_weight;
  logic [W-1:0]  out_c;
  logic          on_output;
  logic          write_enable_output;
  logic [AW-1:0] address_output;
  logic [W-1:0]  data_in_output;
`ifdef CONV_SEQ_BASE_ADDR_EN
  logic [AW-1:0] baseInput;
  logic [AW-1:0] baseWeight;
  logic [AW-1:0] baseOutput;
`endif

  logic [W-1:0] memA [SIZE];
  logic [W-1:0] memB [SIZE];
  logic [W-1:0] rdA;
  logic [W-1:0] rdB;
  logic [W-1:0] accP1;
  logic [W-1:0] accP2;

  expect_t readQ[$];
  expect_t writeQ[$];

  int vectors;
  int miscompares;
  int edgeCount;
  int startEdge;

  conv_stream_sequencer #(
    .NUMHELPER(NH), .INPUT_BITWIDTH(IBW), .SIZE(SIZE), .ACC_LATENCY(LAT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .start(start),
    .length(length),
`ifdef CONV_SEQ_BASE_ADDR_EN
    .base_input(baseInput),
    .base_weight(baseWeight),
    .base_output(baseOutput),
`endif
    .busy(busy),
    .done(done),
    .acc_reset(acc_reset),
    .on_input(on_input),
    .on_weight(on_weight),
    .address_input(address_input),
    .address_weight(address_weight),
    .out_c(out_c),
    .on_output(on_output),
    .write_enable_output(write_enable_output),
    .address_output(address_output),
    .data_in_output(data_in_output)
  );

  // Free-running clock.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Edge counter used to number cycles relative to the start edge.
  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Synchronous-read scratchpads followed by a two-stage XOR accelerator.
  always @(posedge clock) begin
    if (on_input)  rdA <= memA[address_input];
    if (on_weight) rdB <= memB[address_weight];
    accP1 <= rdA ^ rdB;
    accP2 <= accP1;
  end
  assign out_c = accP2;

  task automatic checkOutput(input string tag, input logic [127:0] observed,
                             input logic [127:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic checkResetValues(input string pfx);
    checkOutput({pfx, ".busy"}, 128'(busy), 128'(0));
    checkOutput({pfx, ".done"}, 128'(done), 128'(0));
    checkOutput({pfx, ".accReset"}, 128'(acc_reset), 128'(1));
    checkOutput({pfx, ".onInput"}, 128'(on_input), 128'(0));
    checkOutput({pfx, ".onWeight"}, 128'(on_weight), 128'(0));
    checkOutput({pfx, ".addrIn"}, 128'(address_input), 128'(0));
    checkOutput({pfx, ".addrWeight"}, 128'(address_weight), 128'(0));
    checkOutput({pfx, ".onOutput"}, 128'(on_output), 128'(0));
    checkOutput({pfx, ".wrEn"}, 128'(write_enable_output), 128'(0));
    checkOutput({pfx, ".addrOut"}, 128'(address_output), 128'(0));
    checkOutput({pfx, ".dataOut"}, 128'(data_in_output), 128'(0));
  endtask

  // Scoreboard monitor: every read or write strobe must match the head of
  // its queue in address, data and cycle.
  always @(negedge clock) begin
    int cyc;
    expect_t e;
    cyc = edgeCount - startEdge + 1;
    if (on_input) begin
      if (readQ.size() == 0) begin
        checkOutput("spuriousRead", 128'(1), 128'(0));
      end else begin
        e = readQ.pop_front();
        checkOutput("rdAddrIn", 128'(address_input), 128'(e.addr));
        checkOutput("rdAddrWeight", 128'(address_weight), 128'(e.addrW));
        checkOutput("rdOnWeight", 128'(on_weight), 128'(1));
        checkOutput("rdCycle", 128'(cyc), 128'(e.cycle));
      end
    end
    if (write_enable_output) begin
      if (writeQ.size() == 0) begin
        checkOutput("spuriousWrite", 128'(1), 128'(0));
      end else begin
        e = writeQ.pop_front();
        checkOutput("wrAddr", 128'(address_output), 128'(e.addr));
        checkOutput("wrData", 128'(data_in_output), 128'(e.data));
        checkOutput("wrOnOutput", 128'(on_output), 128'(1));
        checkOutput("wrCycle", 128'(cyc), 128'(e.cycle));
      end
    end
  end

  // Launch one pass, queue its expected traffic and check status outputs
  // cycle by cycle. pulseCycle/resetCycle of 0 disable the interference.
  task automatic applyStimulus(input int len, input int bi, input int bw,
                               input int bo, input int pulseCycle,
                               input int resetCycle);
    logic [127:0] rnd;
    expect_t e;
    int doneCycle;
    int lastCycle;
    logic expBusy;
    logic expDone;
    logic expAcc;
    for (int i = 0; i < SIZE; i++) begin
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      memA[i] = rnd[W-1:0];
      rnd = {$urandom(), $urandom(), $urandom(), $urandom()};
      memB[i] = rnd[W-1:0];
    end
    doneCycle = (len == 0) ? 1 : 4 + (len - 1) + LAT;
    for (int k = 0; k < len; k++) begin
      e.cycle = 1 + k;
      e.addr  = AW'((bi + k) % SIZE);
      e.addrW = AW'((bw + k) % SIZE);
      e.data  = '0;
      if (resetCycle == 0 || e.cycle <= resetCycle) readQ.push_back(e);
      e.cycle = 3 + k + LAT;
      e.addr  = AW'((bo + k) % SIZE);
      e.addrW = '0;
      e.data  = memA[(bi + k) % SIZE] ^ memB[(bw + k) % SIZE];
      if (resetCycle == 0 || e.cycle <= resetCycle) writeQ.push_back(e);
    end
    lastCycle = (resetCycle != 0) ? resetCycle + 15 : doneCycle + 2;

    @(negedge clock);
    start  = 1'b1;
    length = (AW+1)'(len);
`ifdef CONV_SEQ_BASE_ADDR_EN
    baseInput  = AW'(bi);
    baseWeight = AW'(bw);
    baseOutput = AW'(bo);
`endif
    @(posedge clock);
    #1;
    startEdge = edgeCount;
    start  = 1'b0;
    length = (AW+1)'($urandom_range(0, SIZE));
`ifdef CONV_SEQ_BASE_ADDR_EN
    baseInput  = AW'($urandom_range(0, SIZE - 1));
    baseWeight = AW'($urandom_range(0, SIZE - 1));
    baseOutput = AW'($urandom_range(0, SIZE - 1));
`endif

    for (int c = 1; c <= lastCycle; c++) begin
      @(negedge clock);
      if (resetCycle != 0 && c > resetCycle) begin
        expBusy = 1'b0;
        expDone = 1'b0;
        expAcc  = 1'b1;
      end else if (len == 0) begin
        expBusy = (c == 1);
        expDone = (c == 1);
        expAcc  = 1'b1;
      end else begin
        expBusy = (c < doneCycle);
        expDone = (resetCycle == 0) && (c == doneCycle);
        expAcc  = (c >= doneCycle);
      end
      checkOutput($sformatf("busy@%0d", c), 128'(busy), 128'(expBusy));
      checkOutput($sformatf("done@%0d", c), 128'(done), 128'(expDone));
      checkOutput($sformatf("accReset@%0d", c), 128'(acc_reset), 128'(expAcc));
      if (pulseCycle != 0 && c == pulseCycle) begin
        start  = 1'b1;
        length = (AW+1)'(2);
      end
      if (pulseCycle != 0 && c == pulseCycle + 1) start = 1'b0;
      if (resetCycle != 0 && c == resetCycle) begin
        #1 reset = 1'b0;
        #1 checkResetValues("midReset");
      end
      if (resetCycle != 0 && c == resetCycle + 2) reset = 1'b1;
    end
    start = 1'b0;
    checkOutput("readsLeft", 128'(readQ.size()), 128'(0));
    checkOutput("writesLeft", 128'(writeQ.size()), 128'(0));
    readQ.delete();
    writeQ.delete();
    repeat (2) @(negedge clock);
  endtask

  // Test sequence.
  initial begin
    vectors     = 0;
    miscompares = 0;
    edgeCount   = 0;
    startEdge   = 0;
    reset       = 1'b0;
    start       = 1'b0;
    length      = '0;
`ifdef CONV_SEQ_BASE_ADDR_EN
    baseInput   = '0;
    baseWeight  = '0;
    baseOutput  = '0;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkResetValues("inReset");
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checkResetValues("idle");

    $display("[TB] basic pass, length 3");
    applyStimulus(3, 0, 0, 0, 0, 0);
    $display("[TB] single word pass");
    applyStimulus(1, 0, 0, 0, 0, 0);
    $display("[TB] full depth pass");
    applyStimulus(SIZE, 0, 0, 0, 0, 0);
    $display("[TB] zero length pass");
    applyStimulus(0, 0, 0, 0, 0, 0);
    $display("[TB] start pulsed mid-pass");
    applyStimulus(8, 0, 0, 0, 4, 0);
    $display("[TB] reset asserted mid-pass");
    applyStimulus(8, 0, 0, 0, 0, 6);
    $display("[TB] pass after mid-pass reset");
    applyStimulus(5, 0, 0, 0, 0, 0);
`ifdef CONV_SEQ_BASE_ADDR_EN
    $display("[TB] base addresses with wrap-around");
    applyStimulus(4, 14, 14, 15, 0, 0);
    applyStimulus(SIZE, 9, 3, 12, 0, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/conv_stream_sequencer.md
# conv_stream_sequencer

Sequencer for one accelerator pass. It sits between the input/weight scratchpads and the XNOR convolution accelerator on the read side, and drives the output scratchpad on the write side. On a `start` pulse it reads `length` words in lockstep from the input and weight scratchpads, tracks each word through the fixed read and accelerator latency, and writes each accelerator result into the output scratchpad at the matching address. It replaces hand-sequenced addressing in the integration bench with a single reusable control block.

## Interface
- `NUMHELPER`, 4: parallel PE lanes per word.
- `INPUT_BITWIDTH`, 25: bits per lane; word width W = NUMHELPER*INPUT_BITWIDTH.
- `SIZE`, 16: scratchpad depth; AW = $clog2(SIZE).
- `ACC_LATENCY`, 2: cycles from accelerator input to valid `out_c`; must be ≥1.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  begins a pass when sampled high in IDLE.
- `length`  in  AW+1  words per pass, 0..SIZE, captured on the accepted `start`.
- `busy`  out  1  high from the accepted start through the last write.
- `done`  out  1  one-cycle pulse when a pass completes.
- `acc_reset`  out  1  active-high reset to the accelerator; high except during RUN/DRAIN.
- `on_input`, `on_weight`  out  1  read enables for the input and weight scratchpads.
- `address_input`, `address_weight`  out  AW  read addresses; always equal to each other.
- `out_c`  in  W  accelerator result.
- `on_output`, `write_enable_output`  out  1  output scratchpad enable and write enable.
- `address_output`  out  AW  write address.
- `data_in_output`  out  W  registered copy of `out_c`.

## Operation
- States:
  - IDLE → RUN on `start` with `length`>0.
  - IDLE → DONE on `start` with `length`=0. This pass issues no reads and no writes.
  - RUN → DRAIN after the read at address `length`-1 is issued.
  - DRAIN → DONE after the last write is issued.
  - DONE → IDLE unconditionally.
- RUN:
  - `on_input`=`on_weight`=1.
  - Read address counts 0,1,…,`length`-1, one per cycle.
- Scratchpad reads are synchronous: data is valid one cycle after the address is issued.
- A valid/address delay line tracks each issued read. Its depth is 1+ACC_LATENCY, and each entry carries a valid bit and an AW-bit tag.
- When the tag emerges, `out_c` is captured into `data_in_output`. In the same edge, `address_output` is set to the tag and `write_enable_output`=`on_output`=1 for exactly one cycle.
- Write addresses arrive in strictly increasing order with no gaps.
- With `length`=SIZE, the read counter ends at SIZE-1 and does not wrap within a pass.
- `start` during RUN/DRAIN/DONE is ignored. `length` changes after capture are ignored.
- `acc_reset`:
  - Falls in the first RUN cycle.
  - Rises on entry to DONE.
- Reset mid-pass: all state is cleared immediately. The delay line is flushed, no further writes occur, and `done` is not pulsed.

## Timing
- Reset values: `busy`=0, `done`=0, `acc_reset`=1. All enables and write enables are 0; all addresses and data are 0.
- Cycle numbering: cycle 0 is the edge that samples `start`.
- Reads: the read of word k is issued in cycle 1+k.
- Writes: the write strobe for word k is high in cycle 3+k+ACC_LATENCY.
- `done` is high in cycle 4+(`length`-1)+ACC_LATENCY. `busy` falls in the same cycle.
- A new `start` is accepted no earlier than the cycle after `done`.
- Pass with `length`=0: `busy` is high in cycle 1 only, and `done` pulses in cycle 1.
- Outputs are all registered; there is no combinational path from an input to an output.

## Configuration
- `CONV_SEQ_BASE_ADDR_EN`:
  - Defined: adds inputs `base_input`, `base_weight` and `base_output` (AW each), captured on the accepted `start`.
    - Read address = (base_input + k) mod SIZE; likewise for the weight read using `base_weight`.
    - Write address = (base_output + k) mod SIZE.
    - Wrap-around past SIZE-1 to 0 is required behaviour.
  - Undefined: the ports are absent and all bases are 0.

## Test plan
- Reset, then hold idle (`reset` low for 3 cycles, then high, `start`=0) → all outputs at reset values and `acc_reset`=1.
- Basic pass (ACC_LATENCY=2, stub accelerator returning `in_a ^ in_b` after 2 cycles, `length`=3, `start` in cycle 0):
  - Reads at 0,1,2 in cycles 1–3.
  - Writes at 0,1,2 in cycles 5–7, with data matching the XOR of the preloaded words.
  - `done` in cycle 8.
- Full depth (`length`=16) → 16 contiguous writes to addresses 0–15, with no write-enable gap and no duplicated address.
- `length`=0 → no read or write enable ever asserts; `done` in cycle 1; `acc_reset` stays 1.
- Mid-pass interference (`length`=8):
  - `start` pulsed in cycle 4 → ignored, and exactly 8 writes occur.
  - Separately, `reset` low in cycle 6 → outputs return to reset values asynchronously and no `done` pulse follows.
- With `CONV_SEQ_BASE_ADDR_EN` (`base_input`=14, `base_output`=15, `length`=4) → read addresses 14,15,0,1 and write addresses 15,0,1,2.
